// File: rtl/seg_pkg.sv
// Shared constants, frame type and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  mask;
  } disp_frame_t;

  // Blanks leading zero digits (without a decimal point) from the top; digit 0 always stays lit
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] digits, input logic [3:0] dp);
    logic [3:0] m;
    logic       leading;
    m       = '0;
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (leading && (digits[4*i +: 4] == 4'h0) && !dp[i]) begin
        m[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with frame-synchronous data update handshake.
// Optional build macro LEAD_ZERO_SUPPRESS_EN blanks leading zero digits at latch time.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        upd_req,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  output logic        upd_ack,
  output logic [1:0]  an_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int                CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  disp_frame_t      shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [IDX_W-1:0] an_sel_q, an_sel_d;
  logic             ack_q, ack_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             load;
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;
  logic [3:0]       suppress;
  logic [3:0]       one_hot;

  assign tick    = en && (cnt_q == CNT_LAST);
  assign load    = upd_req && (!en || (tick && (idx_q == IDX_LAST)));
  assign nibble  = shadow_q.digits[{idx_q, 2'b00} +: 4];
  assign one_hot = 4'b0001 << idx_q;

`ifdef LEAD_ZERO_SUPPRESS_EN
  assign suppress = lead_zero_mask(digits, dp_in);
`else
  assign suppress = 4'b0000;
`endif

  seg_hex_decode u_hex_decode (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    dp_d     = 1'b1;
    an_sel_d = '0;
    ack_d    = 1'b0;
    frame_d  = 1'b0;

    if (en) begin
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      idx_d    = tick ? idx_q + 1'b1 : idx_q;
      frame_d  = tick && (idx_q == IDX_LAST);
      an_sel_d = idx_q;
      seg_d    = seg_dec;
      dp_d     = ~shadow_q.dp[idx_q];
      // Anodes stay off during the anti-ghosting window and for masked digits
      if ((cnt_q >= CNT_BLANK) && !shadow_q.mask[idx_q]) begin
        an_d = ~one_hot;
      end
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end

    if (load) begin
      shadow_d.digits = digits;
      shadow_d.dp     = dp_in;
      shadow_d.mask   = blank_mask | suppress;
      ack_d           = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      an_sel_q <= '0;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_sel_q <= an_sel_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
    end
  end

  assign upd_ack     = ack_q;
  assign an_sel      = an_sel_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios then randomized traffic against a slot-arithmetic model.
module tb_seg_scan_ctrl;

  localparam int RDIV  = 4;
  localparam int BLANK = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        upd_req;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        upd_ack;
  logic [1:0]  an_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled-cycle count plus per-digit shadow contents
  int         enCycles;
  logic [3:0] shDigit [4];
  logic       shDp    [4];
  logic       shBlank [4];
  logic [6:0] hexRef  [16];

  logic [3:0] expAn;
  logic [6:0] expSeg;
  logic       expDp;
  logic [1:0] expSel;
  logic       expAck;
  logic       expFrame;
  logic       expSegValid;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .upd_req     (upd_req),
    .digits      (digits),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .upd_ack     (upd_ack),
    .an_sel      (an_sel),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("an", 16'(an), 16'(expAn));
    checkVal("an_sel", 16'(an_sel), 16'(expSel));
    checkVal("upd_ack", 16'(upd_ack), 16'(expAck));
    checkVal("frame_start", 16'(frame_start), 16'(expFrame));
    if (expSegValid) begin
      checkVal("seg", 16'(seg), 16'(expSeg));
      checkVal("dp", 16'(dp), 16'(expDp));
    end
  endtask

  // Latch the current request data into the model shadow
  task automatic modelLoad();
    int top;
    for (int i = 0; i < 4; i++) begin
      shDigit[i] = digits[4*i +: 4];
      shDp[i]    = dp_in[i];
      shBlank[i] = blank_mask[i];
    end
`ifdef LEAD_ZERO_SUPPRESS_EN
    top = 0;
    for (int i = 0; i < 4; i++) begin
      if (shDigit[i] != 4'h0 || shDp[i]) top = i;
    end
    for (int i = 0; i < 4; i++) begin
      if (i > top) shBlank[i] = 1'b1;
    end
`else
    top = 0;
`endif
  endtask

  // One clock: predict registered outputs from the pre-edge state, advance, then compare
  task automatic applyStimulus();
    int         digit;
    int         pos;
    bit         tick;
    bit         load;
    logic [3:0] oneHot;
    digit = (enCycles / RDIV) % 4;
    pos   = enCycles % RDIV;
    tick  = en && (pos == RDIV - 1);
    if (rst) begin
      expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expSel = 2'd0;
      expAck = 1'b0; expFrame = 1'b0; expSegValid = 1'b1;
      enCycles = 0;
      for (int i = 0; i < 4; i++) begin
        shDigit[i] = 4'h0; shDp[i] = 1'b0; shBlank[i] = 1'b0;
      end
    end else begin
      if (en) begin
        oneHot      = 4'b0001 << digit;
        expSel      = 2'(digit);
        expSeg      = hexRef[shDigit[digit]];
        expDp       = ~shDp[digit];
        expAn       = (pos < BLANK || shBlank[digit]) ? 4'hF : ~oneHot;
        expFrame    = tick && (digit == 3);
        expSegValid = 1'b1;
        enCycles++;
      end else begin
        expAn = 4'hF; expSel = 2'd0; expFrame = 1'b0; expSegValid = 1'b0;
        enCycles = 0;
      end
      load   = upd_req && (!en || (tick && digit == 3));
      expAck = load;
      if (load) modelLoad();
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Hold the request until acknowledged, bounded; returns number of cycles taken
  task automatic waitAck(input string tag, output int steps);
    steps = 0;
    upd_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      steps++;
      if (upd_ack === 1'b1) break;
    end
    checkVal({tag, "_ack_seen"}, 16'(upd_ack), 16'd1);
    upd_req = 1'b0;
  endtask

  initial begin : main
    logic [3:0] anSeq [16];
    int         frames;
    int         acks;
    int         steps;
    int         sawD1;
    int         sawD0;
    int         sawD3;
    int         litOther;

    hexRef = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    anSeq  = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    enCycles = 0;
    for (int i = 0; i < 4; i++) begin
      shDigit[i] = 4'h0; shDp[i] = 1'b0; shBlank[i] = 1'b0;
    end

    rst = 1'b1; en = 1'b0; upd_req = 1'b0;
    digits = 16'h0000; dp_in = 4'h0; blank_mask = 4'h0;
    applyStimulus();
    applyStimulus();
    checkVal("reset_an", 16'(an), 16'hF);
    checkVal("reset_seg", 16'(seg), 16'h7F);
    checkVal("reset_dp", 16'(dp), 16'd1);
    rst = 1'b0;

    // Free-running scan pattern and frame pulse
    en = 1'b1;
    frames = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      checkVal("scan_seq", 16'(an), 16'(anSeq[i]));
      if (frame_start === 1'b1) frames++;
    end
    checkVal("frame_count", 16'(frames), 16'd1);

    // Update at the frame boundary only
    digits = 16'h1234; dp_in = 4'b0010; blank_mask = 4'h0;
    waitAck("upd1234", steps);
    checkVal("upd_latency", 16'(steps), 16'd16);
    sawD1 = 0; sawD0 = 0; acks = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (upd_ack === 1'b1) acks++;
      if (an === 4'b1101) begin
        sawD1++;
        checkVal("d1_seg", 16'(seg), 16'(7'b0110000));
        checkVal("d1_dp", 16'(dp), 16'd0);
      end
      if (an === 4'b1110) begin
        sawD0++;
        checkVal("d0_seg", 16'(seg), 16'(7'b0011001));
        checkVal("d0_dp", 16'(dp), 16'd1);
      end
    end
    checkVal("single_ack", 16'(acks), 16'd0);
    checkVal("d1_seen", 16'(sawD1), 16'd3);
    checkVal("d0_seen", 16'(sawD0), 16'd3);

    // Mid-frame request with a blank mask on digit 3
    for (int i = 0; i < 6; i++) applyStimulus();
    digits = 16'h5678; dp_in = 4'h0; blank_mask = 4'b1000;
    waitAck("mask", steps);
    checkVal("mask_latency", 16'(steps), 16'd10);
    sawD3 = 0; litOther = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (an === 4'b0111) sawD3++;
      if (an !== 4'hF) litOther++;
    end
    checkVal("mask_d3_dark", 16'(sawD3), 16'd0);
    checkVal("mask_others_lit", 16'(litOther), 16'd9);

    // Enable drop mid-slot, request while disabled, re-enable
    applyStimulus();
    applyStimulus();
    en = 1'b0;
    applyStimulus();
    checkVal("en_drop_an", 16'(an), 16'hF);
    digits = 16'h9ABC; dp_in = 4'b0001; blank_mask = 4'h0;
    waitAck("en0", steps);
    checkVal("en0_latency", 16'(steps), 16'd1);
    applyStimulus();
    en = 1'b1;
    applyStimulus();
    applyStimulus();
    checkVal("restart_sel", 16'(an_sel), 16'd0);
    checkVal("restart_an", 16'(an), 16'hE);

    // Reset with a pending request
    upd_req = 1'b1; digits = 16'hFFFF;
    rst = 1'b1;
    applyStimulus();
    checkVal("rst_ack", 16'(upd_ack), 16'd0);
    checkVal("rst_seg", 16'(seg), 16'h7F);
    rst = 1'b0; upd_req = 1'b0; digits = 16'h0000;
    for (int i = 0; i < 16; i++) applyStimulus();

`ifdef LEAD_ZERO_SUPPRESS_EN
    en = 1'b0;
    digits = 16'h0007; dp_in = 4'h0; blank_mask = 4'h0;
    waitAck("lzs", steps);
    en = 1'b1;
    litOther = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (an !== 4'hF && an !== 4'hE) litOther++;
    end
    checkVal("lzs_only_d0", 16'(litOther), 16'd0);
`endif

    // Randomized traffic with a well-behaved requester
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (upd_req && upd_ack === 1'b1) begin
        upd_req = 1'b0;
      end else if (!upd_req && $urandom_range(0, 5) == 0) begin
        upd_req    = 1'b1;
        digits     = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp_in      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      end
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
